imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It covers every RV32I/RV64I base immediate format (I, S, B, U, J) plus shift-amount immediates, and flags unsupported opcodes. Instructions enter and results leave through valid/ready handshakes, using a 2-entry skid buffer so the fetch side can stream at full rate under back-pressure. A saturating counter records how many illegal opcodes have been accepted.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64. Immediates sign-extend to XLEN. OP-IMM-32 (0011011) and OP-32 (0111011) are legal only when XLEN=64.
CNT_W, 16, width of the illegal-opcode counter.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction on in_instr is valid
in_ready  output  1  block can accept an instruction this cycle
in_instr  input  32  raw instruction word
out_valid  output  1  result registers hold a valid entry
out_ready  input  1  consumer accepts the result this cycle
out_imm  output  XLEN  generated immediate
out_fmt  output  3  format code: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
out_illegal  output  1  opcode is unsupported
out_instr  output  32  instruction word, passed through unchanged
cnt_clr  input  1  synchronous clear of the illegal counter
illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_instr=0.
  - Skid buffer is emptied; illegal_cnt=0.
  - in_ready=0 while rst is high, and 1 in the first cycle after release.
- Decode (combinational from in_instr, captured on accept):
  - I (fmt 1): opcodes 0000011, 0010011, 1100111, and 0011011 when XLEN=64.
    - Default: imm = sext(instr[31:20]).
    - Shifts (opcode 0010011 or 0011011 with funct3 001/101): imm = zero-extended shamt.
      - shamt = instr[24:20] for XLEN=32 or opcode 0011011.
      - shamt = instr[25:20] for XLEN=64 with opcode 0010011.
  - S (fmt 2): 0100011, imm = sext({instr[31:25], instr[11:7]}).
  - B (fmt 3): 1100011, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U (fmt 4): 0110111 and 0010111, imm = sext({instr[31:12], 12'b0}) to XLEN.
  - J (fmt 5): 1101111, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R (fmt 0): 0110011, and 0111011 when XLEN=64; imm=0, illegal=0.
  - Any other opcode, or instr[1:0]!=2'b11: fmt=7, illegal=1, imm=0.
- Handshake:
  - Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
  - Latency is 1 cycle from accept to out_valid when not stalled.
  - Output stage empty, or transferring this cycle, with skid empty: the accepted entry loads the output registers.
  - Output stage holding and stalled (out_valid && !out_ready): the accepted entry goes to the skid register.
  - in_ready is a registered !skid_full. It drops the cycle after the skid fills.
  - On a transfer with skid full: the skid entry moves to the output registers, and in_ready rises the next cycle.
  - Skid drain and a new accept in the same cycle cannot coincide, because in_ready=0 while the skid is full.
  - Outputs stay stable while out_valid && !out_ready.
  - Order is strictly preserved; no entry is ever dropped or duplicated.
- Counter:
  - illegal_cnt increments on each accept of an illegal instruction.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority: if clear and increment happen in the same cycle, the result is 0.
- Reset asserted mid-stream discards all held entries; nothing is emitted after reset.

Test Plan:
1. XLEN=32, send addi 0xFFF00093 then sw 0xFE112E23 with out_ready=1 → out_imm=0xFFFFFFFF with fmt=1 one cycle after accept, then 0xFFFFFFFC with fmt=2.
2. Send jal 0x001000EF, lui 0xABCDE2B7 and srai 0x4030D093 → out_imm=0x00000800 fmt=5; 0xABCDE000 fmt=4; 0x00000003 fmt=1 (shamt, not 0x403). With XLEN=64 the lui result is 0xFFFFFFFFABCDE000.
3. Issue 3 back-to-back accepts while out_ready is held low for 3 cycles → in_ready falls after the 2nd accept. The 3rd instruction is held at the input until in_ready returns. All 3 results appear in order with no loss, and out_imm stays stable while stalled.
4. Send illegal 0x0000000B twice, then assert cnt_clr in the same cycle as a third illegal accept → out_illegal=1 with fmt=7 each time; illegal_cnt reads 1, then 2, then 0.
5. Use CNT_W=2 and send 5 illegal instructions → illegal_cnt saturates at 3.
6. Assert rst while the skid is full and the output is stalled → out_valid=0 and illegal_cnt=0 immediately. in_ready=1 in the first cycle after release, and no stale result is emitted.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with valid/ready handshakes,
// a 2-entry skid buffer and a saturating illegal-opcode counter.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  logic             accept, xfer, load_out;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [2:0]       out_fmt_q, out_fmt_d;
  logic             out_ill_q, out_ill_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [2:0]       skid_fmt_q, skid_fmt_d;
  logic             skid_ill_q, skid_ill_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    opcode   = in_instr[6:0];
    funct3   = in_instr[14:12];
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    dec_imm  = '0;
    dec_fmt  = FMT_ILL;
    dec_ill  = 1'b1;
    if (in_instr[1:0] == 2'b11) begin
      if (opcode == OP_LOAD || opcode == OP_IMM || opcode == OP_JALR ||
          (RV64 && opcode == OP_IMM32)) begin
        dec_fmt = FMT_I;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed(in_instr[31:20]));
        // Shift immediates carry only the shamt; word shifts are always 5 bits.
        if ((opcode == OP_IMM || opcode == OP_IMM32) && is_shift)
          dec_imm = (RV64 && opcode == OP_IMM) ? XLEN'(in_instr[25:20])
                                                : XLEN'(in_instr[24:20]);
      end else if (opcode == OP_STORE) begin
        dec_fmt = FMT_S;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end else if (opcode == OP_BRANCH) begin
        dec_fmt = FMT_B;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end else if (opcode == OP_LUI || opcode == OP_AUIPC) begin
        dec_fmt = FMT_U;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end else if (opcode == OP_JAL) begin
        dec_fmt = FMT_J;
        dec_ill = 1'b0;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end else if (opcode == OP_OP || (RV64 && opcode == OP_OP32)) begin
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
      end
    end
  end

  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;
  assign load_out = !out_valid_q || (xfer && !skid_valid_q);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    out_instr_d  = out_instr_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_instr_d = skid_instr_q;
    if (xfer) begin
      if (skid_valid_q) begin
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_ill_d    = skid_ill_q;
        out_instr_d  = skid_instr_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    // in_ready guarantees the skid is empty whenever an accept happens.
    if (accept) begin
      if (load_out) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_ill_d   = dec_ill;
        out_instr_d = in_instr;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm;
        skid_fmt_d   = dec_fmt;
        skid_ill_d   = dec_ill;
        skid_instr_d = in_instr;
      end
    end
    in_ready_d = !skid_valid_d;
    cnt_d      = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (accept && dec_ill && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= '0;
      out_ill_q    <= 1'b0;
      out_instr_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_ill_q   <= 1'b0;
      skid_instr_q <= '0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      out_instr_q  <= out_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      skid_instr_q <= skid_instr_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  // The flop resets high so in_ready is up as soon as rst releases.
  assign in_ready    = in_ready_q && !rst;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_instr   = out_instr_q;
  assign illegal_cnt = cnt_q;

endmodule
